mega_jsoc_itrace_dct_packer: RTL and testbench
==============================================

Name: mega_jsoc_itrace_dct_packer

Overview:
- Upstream neighbour of the OCI test bench. Packs the per-instruction 2-bit direct-control-transfer (DCT) trace codes into a 30-bit buffer with a 4-bit entry count.
- Publishes the live accumulator as dct_buffer/dct_count, which the OCI test bench consumes.
- Hands completed packets to the trace FIFO over a valid/ready handshake.
- One 15-entry packet register decouples the accumulator from FIFO back-pressure.

Parameters:
- DCT_WIDTH, 30: buffer width in bits; must be 2*MAX_COUNT.
- MAX_COUNT, 15: entries per full packet; must fit in dct_count (4 bits).

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous assert, active-low reset.
- trace_enable  in  1  trace capture on; when low, retires are ignored.
- retire_valid  in  1  one instruction retired this cycle, carrying dct_code.
- retire_ready  out  1  packer can accept a retire this cycle.
- dct_code  in  2  00 sequential, 01 branch not-taken, 10 branch taken, 11 reserved.
- flush_req  in  1  indirect transfer or exception; close the current packet.
- dct_buffer  out  30  live accumulator; newest code in [1:0].
- dct_count  out  4  live entry count, 0..15.
- pkt_valid  out  1  packet register holds a packet.
- pkt_ready  in  1  trace FIFO accepts the packet.
- pkt_buffer  out  30  packet payload.
- pkt_count  out  4  packet entry count, 1..15.
- overflow  out  1  sticky flag: a retire arrived while retire_ready=0.

Behaviour:
- Reset: dct_buffer=0, dct_count=0, pkt_valid=0, pkt_buffer=0, pkt_count=0, overflow=0. State=IDLE.
- Reset asserted mid-packet discards accumulator and packet; no partial output.
- Accept condition: retire_valid & retire_ready & trace_enable.
  - On accept: dct_buffer <= {dct_buffer[27:0], dct_code}; dct_count <= dct_count+1.
  - Code 11 is appended unchanged; no filtering.
- Close condition: accumulator reaches 15 after an accept, or flush_req with post-accept count >= 1.
- Close action, same edge:
  - Packet register <= {post-accept buffer, post-accept count}.
  - pkt_valid <= 1.
  - dct_buffer <= 0, dct_count <= 0.
  - Packet is visible one cycle after the closing retire or flush.
- Retire and flush in the same cycle: the code is included, then the packet closes.
- flush_req with count 0 and no accept: no packet; no state change.
- Packet handshake: packet transfers when pkt_valid & pkt_ready. pkt_valid clears next edge unless a new close occurs on the same edge.
- Close on the same edge as a transfer: the new packet loads and pkt_valid stays 1 (back-to-back, no bubble).
- retire_ready = !(pkt_valid & !pkt_ready & close_would_occur), where close_would_occur is (dct_count==14) | flush_req.
- Close pending while the packet register is full and not draining:
  - The retire stalls.
  - flush_req must be held by its source until retire_ready=1. The packer does not latch it.
- overflow sets when retire_valid & trace_enable & !retire_ready. Cleared only by reset.
- trace_enable falling with count > 0: behaves as flush_req for one cycle (auto-close).
- States (2-bit):
  - IDLE: trace_enable=0. Goes to ACCUM when trace_enable=1.
  - ACCUM: enabled, packet register free or draining. Goes to HOLD when pkt_valid & !pkt_ready after a close. Goes to IDLE when trace_enable=0 and the flush is done.
  - HOLD: packet pending. Returns to ACCUM on transfer.
- Count never exceeds 15; wrap to 0 occurs only via close.

Decomposition:
- Package mega_jsoc_itrace_pkg holds:
  - DCT code constants (SEQ=2'b00, NT=2'b01, TK=2'b10, RSV=2'b11).
  - State encoding.
  - DCT_WIDTH and MAX_COUNT.
- Sub-module: mega_jsoc_itrace_pkt_reg, a one-entry valid/ready holding register.

Test Plan:
- Reset: with reset_n=0 asynchronously mid-cycle, all outputs read 0 immediately.
- Full packet: 15 retires with code 10, pkt_ready=1 -> after the 15th, pkt_valid=1, pkt_buffer=30'h2AAAAAAA, pkt_count=15; dct_count=0 the same cycle.
- Flush: retire 01, 10, 00, then flush_req alone -> pkt_count=3, pkt_buffer=30'h00000018. A second flush with count 0 produces no packet.
- Simultaneous: retire 10 with flush_req at count 2 (buffer 0b0101) -> pkt_count=3, pkt_buffer=30'h16.
- Back-pressure: pkt_ready=0, close packet A, accumulate 14 -> retire_ready=0 on the 15th. With pkt_ready raised, A transfers and B loads on the same edge, pkt_valid stays 1, and overflow=1 if retire_valid was held during the stall.
- Disable: trace_enable drops at count 5 -> packet with pkt_count=5; state IDLE; further retires are ignored and dct_count stays 0.

Source files
------------

// File: rtl/mega_jsoc_itrace_pkg.sv
// Shared types and constants for the instruction-trace DCT packer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mega_jsoc_itrace_pkg;

    localparam int DCT_WIDTH = 30;
    localparam int MAX_COUNT = 15;
    localparam int CNT_WIDTH = 4;

    localparam logic [1:0] DCT_SEQ = 2'b00;
    localparam logic [1:0] DCT_NT  = 2'b01;
    localparam logic [1:0] DCT_TK  = 2'b10;
    localparam logic [1:0] DCT_RSV = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef logic [DCT_WIDTH-1:0] dct_buf_t;
    typedef logic [CNT_WIDTH-1:0] dct_cnt_t;

    typedef struct packed {
        dct_buf_t buffer;
        dct_cnt_t count;
    } dct_pkt_t;

endpackage

// File: rtl/mega_jsoc_itrace_dct_packer_if.sv
// Packet handshake between the DCT packer and the trace FIFO.
// Latency: n/a (wiring only).
// Backpressure: pkt_ready from the FIFO holds pkt_valid/payload stable.
interface mega_jsoc_itrace_dct_packer_if;
    import mega_jsoc_itrace_pkg::*;

    logic     pkt_valid;
    logic     pkt_ready;
    dct_buf_t pkt_buffer;
    dct_cnt_t pkt_count;

    modport master (output pkt_valid, output pkt_buffer, output pkt_count, input pkt_ready);
    modport slave  (input pkt_valid, input pkt_buffer, input pkt_count, output pkt_ready);
endinterface

// File: rtl/mega_jsoc_itrace_pkt_reg.sv
// One-entry valid/ready holding register for closed DCT packets.
// Latency: 1 cycle from load to pkt_valid.
// Backpressure: holds payload while !pkt_ready; a load on a draining edge replaces it bubble-free.
module mega_jsoc_itrace_pkt_reg
    import mega_jsoc_itrace_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     load,
    input  dct_pkt_t load_pkt,
    mega_jsoc_itrace_dct_packer_if.master pkt
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt.pkt_valid  <= 1'b0;
            pkt.pkt_buffer <= '0;
            pkt.pkt_count  <= '0;
        end else if (load) begin
            pkt.pkt_valid  <= 1'b1;
            pkt.pkt_buffer <= load_pkt.buffer;
            pkt.pkt_count  <= load_pkt.count;
        end else if (pkt.pkt_ready) begin
            pkt.pkt_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/mega_jsoc_itrace_dct_packer.sv
// Packs 2-bit per-retire DCT codes into 15-entry packets for the trace FIFO.
// Latency: packet visible 1 cycle after the closing retire/flush.
// Backpressure: retire_ready drops only when a close is due while the packet register is full and not draining.
module mega_jsoc_itrace_dct_packer
    import mega_jsoc_itrace_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       trace_enable,
    input  logic       retire_valid,
    output logic       retire_ready,
    input  logic [1:0] dct_code,
    input  logic       flush_req,
    output dct_buf_t   dct_buffer,
    output dct_cnt_t   dct_count,
    output logic       overflow,
    mega_jsoc_itrace_dct_packer_if.master pkt
);

    logic [1:0] state, state_d;
    logic       close_would;
    logic       accept;
    logic       eff_flush;
    logic       can_close;
    logic       close;
    dct_buf_t   post_buf;
    dct_cnt_t   post_cnt;
    dct_pkt_t   close_pkt;

    assign close_would  = (dct_count == dct_cnt_t'(MAX_COUNT - 1)) | flush_req;
    assign retire_ready = !(pkt.pkt_valid & !pkt.pkt_ready & close_would);
    assign accept       = retire_valid & retire_ready & trace_enable;

    // Dropping trace_enable with entries pending closes them out like a flush.
    assign eff_flush = flush_req | (!trace_enable & (dct_count != '0));

    assign post_buf  = accept ? {dct_buffer[DCT_WIDTH-3:0], dct_code} : dct_buffer;
    assign post_cnt  = dct_count + dct_cnt_t'(accept);
    assign can_close = !pkt.pkt_valid | pkt.pkt_ready;
    assign close     = can_close &
                       ((post_cnt == dct_cnt_t'(MAX_COUNT)) | (eff_flush & (post_cnt != '0)));
    assign close_pkt = '{buffer: post_buf, count: post_cnt};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_buffer <= '0;
            dct_count  <= '0;
        end else if (close) begin
            dct_buffer <= '0;
            dct_count  <= '0;
        end else if (accept) begin
            dct_buffer <= post_buf;
            dct_count  <= post_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (retire_valid & trace_enable & !retire_ready) begin
            overflow <= 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (trace_enable) state_d = ST_ACCUM;
            ST_ACCUM: begin
                if (pkt.pkt_valid & !pkt.pkt_ready)
                    state_d = ST_HOLD;
                else if (!trace_enable & (close | (dct_count == '0)))
                    state_d = ST_IDLE;
            end
            ST_HOLD:  if (pkt.pkt_ready) state_d = ST_ACCUM;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_d;
    end

    mega_jsoc_itrace_pkt_reg u_pkt_reg (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (close),
        .load_pkt (close_pkt),
        .pkt      (pkt)
    );

endmodule

// File: tb/tb_mega_jsoc_itrace_dct_packer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based packet model.
module tb_mega_jsoc_itrace_dct_packer;
    import mega_jsoc_itrace_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       trace_enable;
    logic       retire_valid;
    logic       retire_ready;
    logic [1:0] dct_code;
    logic       flush_req;
    dct_buf_t   dct_buffer;
    dct_cnt_t   dct_count;
    logic       overflow;

    mega_jsoc_itrace_dct_packer_if pkt_if ();

    mega_jsoc_itrace_dct_packer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .trace_enable (trace_enable),
        .retire_valid (retire_valid),
        .retire_ready (retire_ready),
        .dct_code     (dct_code),
        .flush_req    (flush_req),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .overflow     (overflow),
        .pkt          (pkt_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pending codes in order, plus the single packet slot.
    int          codes[$];
    bit          m_pv;
    bit          m_ovf;
    logic [29:0] m_pbuf;
    int          m_pcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] pack_codes();
        logic [29:0] b = '0;
        foreach (codes[i]) b = {b[27:0], 2'(codes[i])};
        return b;
    endfunction

    task automatic model_reset();
        codes.delete();
        m_pv   = 1'b0;
        m_ovf  = 1'b0;
        m_pbuf = '0;
        m_pcnt = 0;
    endtask

    // One clock cycle; called at a negedge, returns at the next negedge.
    task automatic cyc(input bit rv, input logic [1:0] code, input bit fl, input bit en, input bit prdy);
        bit exp_rdy, acc, fl_eff;
        int n;
        retire_valid     = rv;
        dct_code         = code;
        flush_req        = fl;
        trace_enable     = en;
        pkt_if.pkt_ready = prdy;
        #1;
        n = codes.size();
        exp_rdy = !(m_pv && !prdy && (n == 14 || fl));
        chk("retire_ready", 32'(retire_ready), 32'(exp_rdy));
        @(posedge clk);
        acc = rv && exp_rdy && en;
        if (rv && en && !exp_rdy) m_ovf = 1'b1;
        if (acc) codes.push_back(int'(code));
        fl_eff = fl || (!en && n > 0);
        if ((!m_pv || prdy) && ((acc && codes.size() == 15) || (fl_eff && codes.size() > 0))) begin
            m_pbuf = pack_codes();
            m_pcnt = codes.size();
            m_pv   = 1'b1;
            codes.delete();
        end else if (m_pv && prdy) begin
            m_pv = 1'b0;
        end
        @(negedge clk);
        chk("dct_buffer", 32'(dct_buffer), 32'(pack_codes()));
        chk("dct_count", 32'(dct_count), 32'(codes.size()));
        chk("pkt_valid", 32'(pkt_if.pkt_valid), 32'(m_pv));
        chk("pkt_buffer", 32'(pkt_if.pkt_buffer), 32'(m_pbuf));
        chk("pkt_count", 32'(pkt_if.pkt_count), 32'(m_pcnt));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dct_buffer"}, 32'(dct_buffer), 32'd0);
        chk({tag, "_dct_count"}, 32'(dct_count), 32'd0);
        chk({tag, "_pkt_valid"}, 32'(pkt_if.pkt_valid), 32'd0);
        chk({tag, "_pkt_buffer"}, 32'(pkt_if.pkt_buffer), 32'd0);
        chk({tag, "_pkt_count"}, 32'(pkt_if.pkt_count), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        reset_n          = 1'b0;
        trace_enable     = 1'b0;
        retire_valid     = 1'b0;
        dct_code         = DCT_SEQ;
        flush_req        = 1'b0;
        pkt_if.pkt_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;

        // Full packet of taken branches.
        for (int i = 0; i < 15; i++) cyc(1'b1, DCT_TK, 1'b0, 1'b1, 1'b1);
        chk("full_pbuf", 32'(pkt_if.pkt_buffer), 32'h2AAAAAAA);
        chk("full_pcnt", 32'(pkt_if.pkt_count), 32'd15);
        chk("full_dcnt", 32'(dct_count), 32'd0);
        cyc(1'b0, DCT_SEQ, 1'b0, 1'b1, 1'b1);

        // Standalone flush, then an empty flush.
        cyc(1'b1, DCT_NT, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, DCT_TK, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, DCT_SEQ, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, DCT_SEQ, 1'b1, 1'b1, 1'b1);
        chk("flush_pcnt", 32'(pkt_if.pkt_count), 32'd3);
        chk("flush_pbuf", 32'(pkt_if.pkt_buffer), 32'h18);
        cyc(1'b0, DCT_SEQ, 1'b1, 1'b1, 1'b1);
        chk("empty_flush_pv", 32'(pkt_if.pkt_valid), 32'd0);

        // Retire and flush on the same cycle; reserved code passes through elsewhere in random traffic.
        cyc(1'b1, DCT_NT, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, DCT_NT, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, DCT_TK, 1'b1, 1'b1, 1'b1);
        chk("simul_pcnt", 32'(pkt_if.pkt_count), 32'd3);
        chk("simul_pbuf", 32'(pkt_if.pkt_buffer), 32'h16);
        cyc(1'b0, DCT_SEQ, 1'b0, 1'b1, 1'b1);

        // Back-pressure: packet A held, B fills to 14, stall, then back-to-back handoff.
        cyc(1'b1, DCT_RSV, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, DCT_SEQ, 1'b1, 1'b1, 1'b0);
        chk("bp_a_pcnt", 32'(pkt_if.pkt_count), 32'd1);
        for (int i = 0; i < 14; i++) cyc(1'b1, DCT_TK, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, DCT_TK, 1'b0, 1'b1, 1'b0);
        chk("bp_stall_cnt", 32'(dct_count), 32'd14);
        chk("bp_overflow", 32'(overflow), 32'd1);
        cyc(1'b1, DCT_TK, 1'b0, 1'b1, 1'b1);
        chk("bp_b2b_pv", 32'(pkt_if.pkt_valid), 32'd1);
        chk("bp_b_pcnt", 32'(pkt_if.pkt_count), 32'd15);
        chk("bp_b_pbuf", 32'(pkt_if.pkt_buffer), 32'h2AAAAAAA);
        cyc(1'b0, DCT_SEQ, 1'b0, 1'b1, 1'b1);

        // Disable with entries pending auto-closes them; later retires are ignored.
        for (int i = 0; i < 5; i++) cyc(1'b1, DCT_NT, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, DCT_NT, 1'b0, 1'b0, 1'b1);
        chk("dis_pcnt", 32'(pkt_if.pkt_count), 32'd5);
        chk("dis_pbuf", 32'(pkt_if.pkt_buffer), 32'h155);
        for (int i = 0; i < 3; i++) cyc(1'b1, DCT_TK, 1'b0, 1'b0, 1'b1);
        chk("dis_dcnt", 32'(dct_count), 32'd0);

        // Asynchronous reset mid-cycle with a held packet and partial accumulator.
        for (int i = 0; i < 4; i++) cyc(1'b1, DCT_NT, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, DCT_SEQ, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, DCT_TK, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, DCT_TK, 1'b1, 1'b1, 1'b0);
        retire_valid = 1'b0;
        flush_req    = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 15) != 0),
                1'($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
